// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output enabled by defining DIGIT_SERIAL_OVF_EN.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef DIGIT_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef DIGIT_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK:0]   chunk_res;
    logic [CHUNK-1:0] s;
    logic             c;

    always_comb begin
        chunk_res = {1'b0, a_q[CHUNK-1:0]}
                  + {1'b0, b_q[CHUNK-1:0]}
                  + (CHUNK+1)'(carry_q);
        s = chunk_res[CHUNK-1:0];
        c = chunk_res[CHUNK];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef DIGIT_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                // result chunks enter at the top so the LSB chunk ends up at bit 0
                acc_d   = (acc_q >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
                carry_d = c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = c;
`ifdef DIGIT_SERIAL_OVF_EN
                    // carry into the MSB is a^b^s at that bit
                    ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ s[CHUNK-1] ^ c;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef DIGIT_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef DIGIT_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef DIGIT_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
